// File: rtl/riscv_test_mon_pkg.sv
// Shared types and default constants for the RISC-V test monitor.
// Latency: none (types and constants only).
// Backpressure: none.
package riscv_test_mon_pkg;

    typedef enum logic [1:0] {
        STAT_PASS    = 2'b00,
        STAT_FAIL    = 2'b01,
        STAT_UNKNOWN = 2'b10,
        STAT_TIMEOUT = 2'b11
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_SETTLE,
        S_REPORT
    } state_e;

    localparam logic [31:0] DEF_HALT_INST  = 32'hdead10cc;
    localparam logic [31:0] DEF_PASS_MAGIC = 32'h00c0ffee;
    localparam logic [31:0] DEF_FAIL_MAGIC = 32'hdeaddead;

    function automatic status_e classify(input logic [31:0] a0,
                                         input logic [31:0] pass_magic,
                                         input logic [31:0] fail_magic);
        if (a0 == pass_magic)      return STAT_PASS;
        else if (a0 == fail_magic) return STAT_FAIL;
        else                       return STAT_UNKNOWN;
    endfunction

endpackage

// File: rtl/riscv_test_mon_satcnt.sv
// Saturating up-counter; clear takes effect before the increment.
// Latency: count visible one cycle after i_inc.
// Backpressure: none; holds at all ones.
module riscv_test_mon_satcnt #(
    parameter int W = 8
) (
    input  logic         i_Clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? W'(1) : '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/riscv_test_monitor.sv
// Halt/timeout test monitor for ISA runs; o_inst_cnt exists with RISCV_TEST_MON_INSTCNT_EN.
// Latency: o_done SETTLE_CYCLES+1 cycles after the halt, one cycle after a timeout.
// Backpressure: none; i_start outside IDLE is dropped.
module riscv_test_monitor
    import riscv_test_mon_pkg::*;
#(
    parameter logic [31:0] HALT_INST     = DEF_HALT_INST,
    parameter logic [31:0] PASS_MAGIC    = DEF_PASS_MAGIC,
    parameter logic [31:0] FAIL_MAGIC    = DEF_FAIL_MAGIC,
    parameter int          MAX_CYCLES    = 10000,
    parameter int          CNT_W         = 16,
    parameter int          SETTLE_CYCLES = 4,
    parameter int          ID_W          = 6,
    parameter int          SUM_W         = 8
) (
    input  logic             i_Clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [ID_W-1:0]  i_test_id,
    input  logic             i_inst_valid,
    input  logic [31:0]      i_inst_data,
    input  logic [31:0]      i_a0,
    input  logic             i_clear,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_status,
    output logic [CNT_W-1:0] o_cycles,
    output logic [ID_W-1:0]  o_test_id,
    output logic [SUM_W-1:0] o_pass_cnt,
    output logic [SUM_W-1:0] o_fail_cnt,
    output logic [CNT_W-1:0] o_inst_cnt
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LP_LAST_RUN = CNT_W'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_MAX      = CNT_W'(MAX_CYCLES);
    localparam logic [SET_W-1:0] LP_LAST_SET = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_e           r_state;
    status_e          r_status;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_halt_cnt;
    logic [SET_W-1:0] r_settle;
    logic [ID_W-1:0]  r_id;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cycles;
    logic [ID_W-1:0]  r_test_id;

    logic w_halt;
    logic w_accept;
    logic w_report;

    assign w_halt   = i_inst_valid && (i_inst_data == HALT_INST);
    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_report = (r_state == S_REPORT);

    // Reported fields change only on entry to REPORT so they stay stable between o_done pulses.
    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_status   <= STAT_PASS;
            r_cnt      <= '0;
            r_halt_cnt <= '0;
            r_settle   <= '0;
            r_id       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cycles   <= '0;
            r_test_id  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_id    <= i_test_id;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_halt) begin
                        r_halt_cnt <= r_cnt;
                        r_settle   <= '0;
                        if (SETTLE_CYCLES == 0) begin
                            r_state   <= S_REPORT;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_status  <= classify(i_a0, PASS_MAGIC, FAIL_MAGIC);
                            r_cycles  <= r_cnt;
                            r_test_id <= r_id;
                        end else begin
                            r_state <= S_SETTLE;
                        end
                    end else if (r_cnt == LP_LAST_RUN) begin
                        r_state   <= S_REPORT;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_status  <= STAT_TIMEOUT;
                        r_cycles  <= LP_MAX;
                        r_test_id <= r_id;
                    end
                end
                S_SETTLE: begin
                    r_settle <= r_settle + 1'b1;
                    if (r_settle == LP_LAST_SET) begin
                        r_state   <= S_REPORT;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_status  <= classify(i_a0, PASS_MAGIC, FAIL_MAGIC);
                        r_cycles  <= r_halt_cnt;
                        r_test_id <= r_id;
                    end
                end
                S_REPORT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    riscv_test_mon_satcnt #(.W(SUM_W)) u_pass_cnt (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .i_clr   (i_clear),
        .i_inc   (w_report && (r_status == STAT_PASS)),
        .o_cnt   (o_pass_cnt)
    );

    riscv_test_mon_satcnt #(.W(SUM_W)) u_fail_cnt (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .i_clr   (i_clear),
        .i_inc   (w_report && (r_status != STAT_PASS)),
        .o_cnt   (o_fail_cnt)
    );

`ifdef RISCV_TEST_MON_INSTCNT_EN
    riscv_test_mon_satcnt #(.W(CNT_W)) u_inst_cnt (
        .i_Clk   (i_Clk),
        .i_reset (i_reset),
        .i_clr   (w_accept),
        .i_inc   ((r_state == S_RUN) && i_inst_valid),
        .o_cnt   (o_inst_cnt)
    );
`else
    assign o_inst_cnt = '0;
`endif

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_status  = r_status;
    assign o_cycles  = r_cycles;
    assign o_test_id = r_test_id;

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Directed bench: a default-parameter monitor and a MAX_CYCLES=16/SUM_W=2 monitor share one stimulus stream.
module tb_riscv_test_monitor;

    localparam logic [31:0] HALT  = 32'hdead10cc;
    localparam logic [31:0] PASSM = 32'h00c0ffee;
    localparam logic [31:0] FAILM = 32'hdeaddead;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, start, valid, clr;
    logic [5:0]  id;
    logic [31:0] inst, a0;

    logic        a_busy, a_done;
    logic [1:0]  a_status;
    logic [15:0] a_cycles, a_inst;
    logic [5:0]  a_id;
    logic [7:0]  a_pass, a_fail;

    logic        b_busy, b_done;
    logic [1:0]  b_status;
    logic [15:0] b_cycles, b_inst;
    logic [5:0]  b_id;
    logic [1:0]  b_pass, b_fail;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    logic seen;

    always #5 clk = ~clk;

    riscv_test_monitor u_dut_a (
        .i_Clk(clk), .i_reset(rst), .i_start(start), .i_test_id(id),
        .i_inst_valid(valid), .i_inst_data(inst), .i_a0(a0), .i_clear(clr),
        .o_busy(a_busy), .o_done(a_done), .o_status(a_status), .o_cycles(a_cycles),
        .o_test_id(a_id), .o_pass_cnt(a_pass), .o_fail_cnt(a_fail), .o_inst_cnt(a_inst)
    );

    riscv_test_monitor #(.MAX_CYCLES(16), .SUM_W(2)) u_dut_b (
        .i_Clk(clk), .i_reset(rst), .i_start(start), .i_test_id(id),
        .i_inst_valid(valid), .i_inst_data(inst), .i_a0(a0), .i_clear(clr),
        .o_busy(b_busy), .o_done(b_done), .o_status(b_status), .o_cycles(b_cycles),
        .o_test_id(b_id), .o_pass_cnt(b_pass), .o_fail_cnt(b_fail), .o_inst_cnt(b_inst)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One test on the default monitor: halt at RUN count halt_at, a0 applied after the halt.
    // lat counts cycles from the halt cycle to the o_done cycle.
    task automatic run(input logic [5:0] tid, input int halt_at, input logic [31:0] a0_val,
                       input bit clr_rep, input bit bubbles, output int l);
        id    = tid;
        start = 1'b1;
        tick;
        start = 1'b0;
        id    = '0;
        a0    = '0;
        for (int c = 0; c < halt_at; c++) begin
            valid = !(bubbles && (c % 4 == 3) && (c < 28));
            inst  = NOP;
            tick;
        end
        valid = 1'b1;
        inst  = HALT;
        tick;
        l     = 1;
        valid = 1'b0;
        inst  = '0;
        a0    = a0_val;
        while (!a_done && l < 64) begin
            tick;
            l++;
        end
        if (clr_rep) clr = 1'b1;
        tick;
        clr = 1'b0;
        a0  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; valid = 1'b0; clr = 1'b0;
        id = '0; inst = '0; a0 = '0;
        tick;
        tick;
        check("rst_done",   a_done,   0);
        check("rst_busy",   a_busy,   0);
        check("rst_status", a_status, 0);
        check("rst_cycles", a_cycles, 0);
        check("rst_id",     a_id,     0);
        check("rst_pass",   a_pass,   0);
        check("rst_fail",   a_fail,   0);
        check("rst_inst",   a_inst,   0);
        check("rst_b_pass", b_pass,   0);
        rst = 1'b0;
        tick;

        run(6'd5, 37, PASSM, 1'b0, 1'b0, lat);
        check("t1_latency", lat,      5);
        check("t1_status",  a_status, 0);
        check("t1_cycles",  a_cycles, 37);
        check("t1_id",      a_id,     5);
        check("t1_pass",    a_pass,   1);
        check("t1_fail",    a_fail,   0);
        check("t1_b_timeout_fail", b_fail, 1);

        run(6'd6, 12, FAILM, 1'b0, 1'b0, lat);
        check("t2_status",  a_status, 1);
        check("t2_cycles",  a_cycles, 12);
        check("t2_fail",    a_fail,   1);
        check("t2_pass",    a_pass,   1);
        check("t2_b_status", b_status, 1);

        run(6'd7, 12, 32'h12345678, 1'b0, 1'b0, lat);
        check("t3_status",  a_status, 2);
        check("t3_fail",    a_fail,   2);
        check("t3_b_fail_sat", b_fail, 3);

        // Timeout on the short monitor; the default one keeps running and is then reset at count 20.
        id    = 6'd9;
        start = 1'b1;
        tick;
        start = 1'b0;
        id    = '0;
        lat   = 0;
        while (!b_done && lat < 100) begin
            if (lat == 5) begin
                start = 1'b1;
                id    = 6'd3;
            end
            tick;
            start = 1'b0;
            id    = '0;
            lat++;
        end
        check("to_latency", lat,      16);
        check("to_status",  b_status, 3);
        check("to_cycles",  b_cycles, 16);
        check("to_id",      b_id,     9);
        check("to_a_busy",  a_busy,   1);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            seen = seen | a_done;
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("rst_run_busy", a_busy, 0);
        check("rst_run_pass", a_pass, 0);
        check("rst_run_fail", a_fail, 0);
        check("rst_run_b_fail", b_fail, 0);
        for (int k = 0; k < 10; k++) begin
            tick;
            seen = seen | a_done;
        end
        check("rst_run_no_done", seen, 0);

        run(6'd10, 15, PASSM, 1'b0, 1'b0, lat);
        check("h15_latency", lat,      5);
        check("h15_b_status", b_status, 0);
        check("h15_b_cycles", b_cycles, 15);
        check("h15_b_pass",   b_pass,   1);
        check("h15_a_cycles", a_cycles, 15);
        check("h15_a_id",     a_id,     10);
        check("h15_a_pass",   a_pass,   1);

        clr = 1'b1;
        tick;
        clr = 1'b0;
        check("clr_b_pass", b_pass, 0);
        check("clr_a_pass", a_pass, 0);
        for (int k = 0; k < 5; k++) run(6'd11, 2, PASSM, 1'b0, 1'b0, lat);
        check("sat_b_pass", b_pass, 3);
        check("sat_a_pass", a_pass, 5);
        run(6'd12, 2, PASSM, 1'b1, 1'b0, lat);
        check("clr_rep_b_pass", b_pass, 1);
        check("clr_rep_a_pass", a_pass, 1);

        run(6'd13, 36, PASSM, 1'b0, 1'b1, lat);
        check("ic_cycles", a_cycles, 36);
        check("ic_status", a_status, 0);
`ifdef RISCV_TEST_MON_INSTCNT_EN
        check("ic_inst_cnt", a_inst, 30);
`else
        check("ic_inst_cnt_off", a_inst, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
